mips_controller: RTL and testbench

MIPS_CONTROLLER -- requirements
Module: mips_controller

---
 rtl/mips_controller.sv | 207 ++++++++++++++++++++
 tb/tb_mips_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_controller.sv
//------------------------------------------------------------------------------
// Module      : mips_controller
// Description : Multicycle MIPS control unit: Moore FSM plus ALU decoder,
//               driving a packed control bus to the datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic [14:0] control_bus,
  output logic        illegal_op
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  localparam logic [5:0] c_FN_ADD   = 6'b100000;
  localparam logic [5:0] c_FN_SUB   = 6'b100010;
  localparam logic [5:0] c_FN_AND   = 6'b100100;
  localparam logic [5:0] c_FN_OR    = 6'b100101;
  localparam logic [5:0] c_FN_SLT   = 6'b101010;

  localparam logic [14:0] c_RESET_BUS = 15'h0002;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        w_iord;
  logic        w_mem_write;
  logic        w_ir_write;
  logic        w_pc_write;
  logic        w_branch;
  logic        w_alu_src_a;
  logic        w_reg_write;
  logic        w_reg_dst;
  logic        w_mem_to_reg;
  logic [1:0]  w_pc_src;
  logic [1:0]  w_alu_src_b;
  logic [1:0]  w_alu_op;
  logic        w_illegal;
  logic        w_funct_ok;
  logic        w_pc_en;
  logic [2:0]  w_alu_control;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_funct_ok = 1'b0;
    case (funct)
      c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: w_funct_ok = 1'b1;
      default:                                         w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = FETCH;
    w_iord       = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_alu_src_a  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_pc_src     = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_illegal    = 1'b0;

    case (r_state)
      FETCH: begin
        w_next      = DECODE;
        w_ir_write  = 1'b1;
        w_pc_write  = 1'b1;
        w_alu_src_b = 2'b01;
      end
      DECODE: begin
        w_alu_src_b = 2'b11;
        case (opcode)
          c_OP_LW, c_OP_SW: w_next = MEMADR;
          c_OP_RTYPE:       w_next = EXECUTE;
          c_OP_BEQ:         w_next = BRANCH;
          c_OP_ADDI:        w_next = ADDIEXEC;
          c_OP_J:           w_next = JUMP;
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        w_next      = (opcode == c_OP_LW) ? MEMRD : MEMWR;
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      MEMRD: begin
        w_next = MEMWB;
        w_iord = 1'b1;
      end
      MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      EXECUTE: begin
        w_next      = ALUWB;
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_illegal   = !w_funct_ok;
      end
      ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_branch    = 1'b1;
      end
      ADDIEXEC: begin
        w_next      = ADDIWB;
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      ADDIWB: begin
        w_reg_write = 1'b1;
      end
      JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
      end
      // Unused encodings fall back to FETCH with all enables off.
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    w_alu_control = 3'b010;
    case (w_alu_op)
      2'b00: w_alu_control = 3'b010;
      2'b01: w_alu_control = 3'b110;
      2'b10: begin
        case (funct)
          c_FN_ADD: w_alu_control = 3'b010;
          c_FN_SUB: w_alu_control = 3'b110;
          c_FN_AND: w_alu_control = 3'b000;
          c_FN_OR:  w_alu_control = 3'b001;
          c_FN_SLT: w_alu_control = 3'b111;
          default:  w_alu_control = 3'b010;
        endcase
      end
      default: w_alu_control = 3'b010;
    endcase
  end

  assign w_pc_en = w_pc_write | (w_branch & zero);

  // Reset gates the bus directly so enables drop without waiting for a clock.
  always_comb begin
    control_bus = c_RESET_BUS;
    illegal_op  = 1'b0;
    if (reset_n) begin
      control_bus = {w_iord, w_mem_write, w_ir_write, w_pc_en, w_alu_src_a,
                     w_reg_write, w_reg_dst, w_mem_to_reg, w_pc_src,
                     w_alu_src_b, w_alu_control};
      illegal_op  = w_illegal;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_mips_controller
// Description : Directed-vector scoreboard bench for mips_controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_controller;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic [14:0] control_bus;
  logic        illegal_op;

  typedef struct {
    string       name;
    logic [14:0] bus;
    logic        ill;
  } exp_t;

  exp_t q[$];
  event do_check;
  int   n_cmp;
  int   n_err;

  mips_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .control_bus (control_bus),
    .illegal_op  (illegal_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: compares DUT outputs against queued expectations when strobed.
  initial begin
    exp_t e;
    n_cmp = 0;
    n_err = 0;
    forever begin
      @(do_check);
      while (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (control_bus !== e.bus || illegal_op !== e.ill) begin
          n_err++;
          $display("FAIL %s: got bus=%h ill=%b, expected bus=%h ill=%b",
                   e.name, control_bus, illegal_op, e.bus, e.ill);
        end
      end
    end
  end

  task automatic expect_now(input string name, input logic [14:0] bus, input logic ill);
    exp_t e;
    e.name = name;
    e.bus  = bus;
    e.ill  = ill;
    q.push_back(e);
    ->do_check;
    #0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  localparam logic [14:0] E_RESET  = 15'h0002;
  localparam logic [14:0] E_FETCH  = 15'h180A;
  localparam logic [14:0] E_DECODE = 15'h001A;
  localparam logic [14:0] E_MEMADR = 15'h0412;
  localparam logic [14:0] E_MEMRD  = 15'h4002;
  localparam logic [14:0] E_MEMWB  = 15'h0282;
  localparam logic [14:0] E_MEMWR  = 15'h6002;
  localparam logic [14:0] E_ALUWB  = 15'h0302;
  localparam logic [14:0] E_ADDIWB = 15'h0202;
  localparam logic [14:0] E_JUMP   = 15'h0842;

  // funct vectors with EXECUTE bus (ALUSrcA plus ALUControl) and illegal flag
  logic [5:0]  fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
  logic [14:0] fn_bus  [6] = '{15'h0402, 15'h0406, 15'h0400, 15'h0401, 15'h0407, 15'h0402};
  logic        fn_ill  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset_n = 1'b0;
    opcode  = 6'b100011;
    funct   = 6'b000000;
    zero    = 1'b0;
    #1;
    expect_now("reset_held", E_RESET, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    expect_now("fetch_after_reset", E_FETCH, 1'b0);

    // lw: FETCH DECODE MEMADR MEMRD MEMWB
    step(); expect_now("lw_decode", E_DECODE, 1'b0);
    step(); expect_now("lw_memadr", E_MEMADR, 1'b0);
    step(); expect_now("lw_memrd", E_MEMRD, 1'b0);
    step(); expect_now("lw_memwb", E_MEMWB, 1'b0);
    step(); expect_now("lw_back_fetch", E_FETCH, 1'b0);

    // sw
    opcode = 6'b101011;
    step(); expect_now("sw_decode", E_DECODE, 1'b0);
    step(); expect_now("sw_memadr", E_MEMADR, 1'b0);
    step(); expect_now("sw_memwr", E_MEMWR, 1'b0);
    step(); expect_now("sw_back_fetch", E_FETCH, 1'b0);

    // R-type across all funct vectors
    opcode = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      step(); expect_now($sformatf("rtype_decode_%0d", i), E_DECODE, 1'b0);
      step(); expect_now($sformatf("rtype_execute_%b", fn_tab[i]), fn_bus[i], fn_ill[i]);
      step(); expect_now($sformatf("rtype_aluwb_%0d", i), E_ALUWB, 1'b0);
      step(); expect_now($sformatf("rtype_fetch_%0d", i), E_FETCH, 1'b0);
    end

    // beq: zero reaches PCEn combinationally only in BRANCH
    opcode = 6'b000100;
    zero   = 1'b1;
    step(); expect_now("beq_decode_zero_ignored", E_DECODE, 1'b0);
    step(); expect_now("beq_branch_taken", 15'h0C26, 1'b0);
    zero = 1'b0;
    #1;
    expect_now("beq_branch_not_taken", 15'h0426, 1'b0);
    step(); expect_now("beq_back_fetch", E_FETCH, 1'b0);

    // addi
    opcode = 6'b001000;
    step(); expect_now("addi_decode", E_DECODE, 1'b0);
    step(); expect_now("addi_exec", E_MEMADR, 1'b0);
    step(); expect_now("addi_wb", E_ADDIWB, 1'b0);
    step(); expect_now("addi_back_fetch", E_FETCH, 1'b0);

    // j
    opcode = 6'b000010;
    step(); expect_now("j_decode", E_DECODE, 1'b0);
    step(); expect_now("j_jump", E_JUMP, 1'b0);
    step(); expect_now("j_back_fetch", E_FETCH, 1'b0);

    // illegal opcode
    opcode = 6'b111111;
    step(); expect_now("illegal_decode", E_DECODE, 1'b1);
    step(); expect_now("illegal_back_fetch", E_FETCH, 1'b0);

    // reset pulse during MEMWR
    opcode = 6'b101011;
    step(); expect_now("rst_sw_decode", E_DECODE, 1'b0);
    step(); expect_now("rst_sw_memadr", E_MEMADR, 1'b0);
    step(); expect_now("rst_sw_memwr", E_MEMWR, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    expect_now("rst_async_drop", E_RESET, 1'b0);
    step(); expect_now("rst_held_over_edge", E_RESET, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    expect_now("rst_resume_fetch", E_FETCH, 1'b0);
    step(); expect_now("rst_resume_decode", E_DECODE, 1'b0);

    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
